// File: rtl/pipe_mux_pkg.sv
// Shared types and helpers for the pipelined N:1 operand selector.
package pipe_mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // Select width, never narrower than one bit so a 2:1 still has a port.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_mux_nx1_mux.sv
// Combinational N:1 selector; flags selects that name no input.
module mux_nx1 import pipe_mux_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  localparam int SEL_W = sel_w(N_IN)
) (
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      dout,
  output logic                  oor
);

  // No match leaves dout at zero and oor set.
  always_comb begin
    dout = '0;
    oor  = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        dout = in_data[k*WIDTH +: WIDTH];
        oor  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_mux_nx1.sv
// N:1 selector with a registered valid/ready output and a 2-entry skid buffer.
// Optional PIPE_MUX_SEL_CHK_EN: zero out-of-range beats and raise a sticky SEL_ERR.
module pipe_mux_nx1 import pipe_mux_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  localparam int SEL_W = sel_w(N_IN)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [N_IN*WIDTH-1:0] IN_DATA,
  input  logic [SEL_W-1:0]      IN_SEL,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic                  FLUSH,
  output logic [WIDTH-1:0]      OUT_DATA,
  output logic [SEL_W-1:0]      OUT_SEL,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  SEL_ERR
);

  state_t             state;
  logic [WIDTH-1:0]   main_d, skid_d, mux_d, cap_d;
  logic [SEL_W-1:0]   main_s, skid_s;
  logic               oor, accept, drain;

  mux_nx1 #(.WIDTH(WIDTH), .N_IN(N_IN)) u_mux (
    .in_data (IN_DATA),
    .sel     (IN_SEL),
    .dout    (mux_d),
    .oor     (oor)
  );

`ifdef PIPE_MUX_SEL_CHK_EN
  assign cap_d = mux_d;
`else
  // Out-of-range falls back to input 0, like the legacy default arm.
  assign cap_d = oor ? IN_DATA[WIDTH-1:0] : mux_d;
`endif

  assign IN_READY  = (state != TWO);
  assign OUT_VALID = (state != EMPTY);
  assign OUT_DATA  = main_d;
  assign OUT_SEL   = main_s;
  assign accept    = IN_VALID & IN_READY & ~FLUSH & ~RESET;
  assign drain     = OUT_VALID & OUT_READY;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= EMPTY;
      main_d <= '0;
      main_s <= '0;
      skid_d <= '0;
      skid_s <= '0;
    end else if (FLUSH) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          main_d <= cap_d;
          main_s <= IN_SEL;
          state  <= ONE;
        end
        ONE: begin
          if (accept && drain) begin
            main_d <= cap_d;
            main_s <= IN_SEL;
          end else if (accept) begin
            skid_d <= cap_d;
            skid_s <= IN_SEL;
            state  <= TWO;
          end else if (drain) begin
            state <= EMPTY;
          end
        end
        TWO: if (drain) begin
          main_d <= skid_d;
          main_s <= skid_s;
          state  <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef PIPE_MUX_SEL_CHK_EN
  logic sel_err_q;
  always_ff @(posedge CLK) begin
    if (RESET)              sel_err_q <= 1'b0;
    else if (accept && oor) sel_err_q <= 1'b1;
  end
  assign SEL_ERR = sel_err_q;
`else
  assign SEL_ERR = 1'b0;
`endif

endmodule

// File: doc/pipe_mux_nx1.md
# pipe_mux_nx1

Parametrised N-input, WIDTH-bit selector with a registered, back-pressured output stage. It is the pipelined successor of the plain 2:1 combinational operand mux. It sits between pipeline stages of the RV32IM core wherever a selected operand must cross a stage boundary under valid/ready flow control: forwarding selects, writeback source select, PC source select. A 2-entry skid buffer gives full throughput with a fully registered IN_READY.

## Interface
- WIDTH, 32: data width in bits.
- N_IN, 4: number of selectable inputs, 2..16.
- SEL_W, max(1, $clog2(N_IN)): select width, derived and not overridden.

- CLK  in  1  rising-edge clock.
- RESET  in  1  synchronous, active-high reset.
- IN_DATA  in  N_IN*WIDTH  packed inputs; input k is at [k*WIDTH +: WIDTH].
- IN_SEL  in  SEL_W  binary select, sampled with the beat.
- IN_VALID  in  1  upstream beat valid.
- IN_READY  out  1  block can accept a beat this cycle.
- FLUSH  in  1  synchronous discard of all held and incoming beats.
- OUT_DATA  out  WIDTH  selected data.
- OUT_SEL  out  SEL_W  select value that produced OUT_DATA.
- OUT_VALID  out  1  output beat valid.
- OUT_READY  in  1  downstream accepts.
- SEL_ERR  out  1  out-of-range select flag (see Configuration).

## Operation
- Accept = IN_VALID & IN_READY & !FLUSH & !RESET. Drain = OUT_VALID & OUT_READY.
- On accept, IN_DATA[IN_SEL] and IN_SEL are captured into the main register if it will be free at the clock edge, otherwise into the skid register.
- States (pipe_mux_pkg::state_t):
  - EMPTY
  - ONE: main register valid.
  - TWO: main and skid registers valid.
- Transitions:
  - EMPTY: accept -> ONE.
  - ONE: accept & !drain -> TWO. Drain & !accept -> EMPTY. Accept & drain -> ONE, with main loaded with the new beat.
  - TWO: no accept. Drain -> ONE, with main <= skid.
- IN_READY = (state != TWO), taken from state flops only. No combinational path from OUT_READY.
- OUT_VALID = (state != EMPTY). OUT_DATA and OUT_SEL are driven from the main register.
- Beats leave in acceptance order. No beat is duplicated or lost unless FLUSH or RESET is applied.
- OUT_DATA and OUT_SEL hold stable while OUT_VALID & !OUT_READY.
- FLUSH: next state is EMPTY. A beat presented in the same cycle is dropped, and a drain in the same cycle still counts as delivered. Data registers are left unchanged.
- Priority: RESET > FLUSH > normal operation.
- Reset values: state EMPTY, OUT_VALID 0, OUT_DATA 0, OUT_SEL 0, SEL_ERR 0, IN_READY 1 (since state is EMPTY). Beats presented while RESET is high are ignored.
- RESET asserted mid-stream discards both held beats.

## Timing
- Latency: a beat accepted at edge t is presented on OUT_* from edge t through at least the following cycle. That is one cycle of latency, zero combinational in-to-out paths.
- Throughput: 1 beat/cycle while OUT_READY is held high.
- After OUT_READY deasserts, IN_READY drops at most one edge later, once the skid register is occupied.
- Restart: IN_READY returns one edge after the first drain in state TWO.

## Configuration
- PIPE_MUX_SEL_CHK_EN, undefined:
  - An IN_SEL value >= N_IN selects input 0, matching the default-arm behaviour of the existing 2:1 mux.
  - SEL_ERR is tied to 0.
- PIPE_MUX_SEL_CHK_EN, defined:
  - An accepted beat with IN_SEL >= N_IN is stored with data 0.
  - SEL_ERR becomes a sticky flag, set at the accepting edge and cleared only by RESET.
  - The beat still flows normally, and OUT_SEL carries the raw select value.

## Structure
- Package pipe_mux_pkg:
  - state_t enum {EMPTY, ONE, TWO}.
  - sel_w(n) function returning max(1, $clog2(n)).
- Sub-module mux_nx1, purely combinational:
  - Parameters WIDTH, N_IN.
  - Ports: packed inputs, select, output, and an out-of-range indicator.
  - Instantiated once at the capture point.
- The top module holds the FSM, the main and skid registers, and the SEL_ERR flop.

## Test plan
- Reset, then push IN_SEL=2 with input 2 = 32'hDEAD_BEEF, with OUT_READY=1 -> OUT_VALID=1, OUT_DATA=32'hDEAD_BEEF, OUT_SEL=2 one edge later. IN_READY stays 1.
- Stream 8 beats, each with select k mod 4 and input j = 32'h100*j + k, with OUT_READY=1 -> 8 output beats in order, values correct, no bubbles.
- Hold OUT_READY=0 and push 3 beats A, B, C -> A and B accepted, IN_READY=0 from the second edge, C stalled. Release OUT_READY -> A, B, C delivered in order.
- In state TWO, assert FLUSH with IN_VALID=1 -> OUT_VALID=0 next edge, and the presented beat is absent from the output.
- Assert RESET for one cycle while in state TWO -> OUT_VALID=0, OUT_DATA=0, IN_READY=1 next cycle.
- N_IN=3, IN_SEL=3 -> without the macro: OUT_DATA = input 0, SEL_ERR=0. With PIPE_MUX_SEL_CHK_EN defined: OUT_DATA=0, OUT_SEL=3, SEL_ERR=1 until RESET.
